// File: rtl/qoa_pkg.sv
// Shared constants, phase encoding and residual unpacking for the QOA frame parser.
package qoa_pkg;

   localparam int unsigned LMS_BYTES      = 16;
   localparam int unsigned SLICE_BYTES    = 8;
   localparam int unsigned RES_PER_SLICE  = 20;
   localparam int unsigned LMS_WORDS      = 8;
   localparam int unsigned LMS_UNIT_BYTES = LMS_BYTES / LMS_WORDS;

   localparam logic OUT_KIND_LMS = 1'b0;
   localparam logic OUT_KIND_RES = 1'b1;

   typedef enum logic {
      PHASE_LMS   = 1'b0,
      PHASE_SLICE = 1'b1
   } phase_e;

   // Residual item k of a big-endian 64-bit slice: {9'b0, sf[3:0], qr[2:0]}
   function automatic logic [15:0] res_item(input logic [63:0] slice, input logic [4:0] k);
      logic [63:0] shifted;
      logic [5:0]  amount;
      amount  = 6'd57 - 6'(3 * k);
      shifted = slice >> amount;
      return {9'b0, slice[63:60], shifted[2:0]};
   endfunction

endpackage

// File: rtl/qoa_residual_emitter.sv
// Emit register: holds one collected unit and presents its items over valid/ready.
module qoa_residual_emitter
   import qoa_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [63:0] load_data,
   input  logic        load_kind,
   input  logic        load_lms_last,
   output logic        can_load,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [15:0] out_data,
   output logic        out_last
);

   localparam logic [4:0] LAST_RES = 5'(RES_PER_SLICE - 1);

   logic [63:0] emit_q, emit_d;
   logic [4:0]  idx_q, idx_d;
   logic        valid_q, valid_d;
   logic        kind_q, kind_d;
   logic [15:0] data_q, data_d;
   logic        last_q, last_d;

   logic        fire;
   logic        final_item;
   logic [4:0]  idx_inc;

   // An LMS unit is a single item; a slice unit ends on its 20th residual.
   assign final_item = (kind_q == OUT_KIND_RES) ? (idx_q == LAST_RES) : 1'b1;
   assign fire       = valid_q && out_ready;
   assign can_load   = !valid_q || (fire && final_item);
   assign idx_inc    = idx_q + 5'd1;

   // Next emit state: load a new unit, or step to the next item on handshake
   always_comb begin
      emit_d  = emit_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      kind_d  = kind_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         emit_d  = load_data;
         idx_d   = '0;
         valid_d = 1'b1;
         kind_d  = load_kind;
         if (load_kind == OUT_KIND_RES) begin
            data_d = res_item(load_data, 5'd0);
            last_d = 1'b0;
         end else begin
            data_d = load_data[15:0];
            last_d = load_lms_last;
         end
      end else if (fire) begin
         if (final_item) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            idx_d  = idx_inc;
            data_d = res_item(emit_q, idx_inc);
            last_d = (idx_inc == LAST_RES);
         end
      end
   end

   // Emit state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         emit_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         kind_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         emit_q  <= emit_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         kind_q  <= kind_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_kind  = kind_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/qoa_frame_parser.sv
// QOA frame parser: collects SPI bytes into LMS words / slices and hands them to the emitter.
module qoa_frame_parser
   import qoa_pkg::*;
#(
   parameter int unsigned SLICES_PER_FRAME = 256
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        data_rdy,
   input  logic [7:0]  spi_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        overflow
);

   localparam logic [7:0] LAST_SLICE = 8'(SLICES_PER_FRAME - 1);
   localparam logic [2:0] LAST_WORD  = 3'(LMS_WORDS - 1);

   logic [1:0]  rst_sync_q;
   logic        rst_n;

   phase_e      phase_q, phase_d;
   logic [2:0]  lms_cnt_q, lms_cnt_d;
   logic [7:0]  slice_cnt_q, slice_cnt_d;
   logic [3:0]  unit_bytes;

   logic [63:0] col_data_q, col_data_d;
   logic [3:0]  col_cnt_q, col_cnt_d;
   logic        col_full_q, col_full_d;
   logic        overflow_q, overflow_d;

   logic        can_load;
   logic        xfer;
   logic        accept;

   // Reset synchroniser: assert immediately, release two clocks later
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rst_sync_q <= '0;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign xfer = col_full_q && can_load;
   // A transfer frees the collect register in the same cycle, so a byte then is not lost.
   assign accept = data_rdy && (!col_full_q || xfer);

   // Phase state register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= PHASE_LMS;
         lms_cnt_q   <= '0;
         slice_cnt_q <= '0;
      end else begin
         phase_q     <= phase_d;
         lms_cnt_q   <= lms_cnt_d;
         slice_cnt_q <= slice_cnt_d;
      end
   end

   // Phase next-state: advance on each transferred unit
   always_comb begin
      phase_d     = phase_q;
      lms_cnt_d   = lms_cnt_q;
      slice_cnt_d = slice_cnt_q;
      if (xfer) begin
         if (phase_q == PHASE_LMS) begin
            if (lms_cnt_q == LAST_WORD) begin
               lms_cnt_d = '0;
               phase_d   = PHASE_SLICE;
            end else begin
               lms_cnt_d = lms_cnt_q + 3'd1;
            end
         end else begin
            if (slice_cnt_q == LAST_SLICE) begin
               slice_cnt_d = '0;
               phase_d     = PHASE_LMS;
            end else begin
               slice_cnt_d = slice_cnt_q + 8'd1;
            end
         end
      end
   end

   // Phase outputs: unit size for the byte being collected (next phase, as a transfer may switch it)
   always_comb begin
      unit_bytes = (phase_d == PHASE_LMS) ? 4'(LMS_UNIT_BYTES) : 4'(SLICE_BYTES);
   end

   // Collect register next-state and sticky overflow
   always_comb begin
      col_data_d = col_data_q;
      col_cnt_d  = col_cnt_q;
      col_full_d = col_full_q;
      overflow_d = overflow_q | (data_rdy & ~accept);
      if (xfer) begin
         col_data_d = '0;
         col_cnt_d  = '0;
         col_full_d = 1'b0;
      end
      if (accept) begin
         col_data_d = {col_data_d[55:0], spi_in};
         col_cnt_d  = col_cnt_d + 4'd1;
         if (col_cnt_d == unit_bytes) col_full_d = 1'b1;
      end
   end

   // Collect registers
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         col_data_q <= '0;
         col_cnt_q  <= '0;
         col_full_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         col_data_q <= col_data_d;
         col_cnt_q  <= col_cnt_d;
         col_full_q <= col_full_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

   qoa_residual_emitter u_emitter (
      .clk           (sys_clk),
      .rst_n         (rst_n),
      .load          (xfer),
      .load_data     (col_data_q),
      .load_kind     ((phase_q == PHASE_LMS) ? OUT_KIND_LMS : OUT_KIND_RES),
      .load_lms_last (lms_cnt_q == LAST_WORD),
      .can_load      (can_load),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_kind      (out_kind),
      .out_data      (out_data),
      .out_last      (out_last)
   );

endmodule
